// File: rtl/dmem_bus_if.sv
// rtl/dmem_bus_if.sv - MEM-stage data access unit: core load/store to req/ack word bus
// Handles lane steering, strobes, load extension, pipeline stall, misalign and timeout errors.
module dmem_bus_if #(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_re,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [2:0]        cpu_dm_ctrl,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              misalign_err,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  tmo_cnt;
   logic [1:0]  lat_off;
   logic [2:0]  lat_dm;
   logic        valid, aligned, accept, ack_hit, timeout_hit;
   logic [31:0] wdata_lane, load_ext;
   logic [3:0]  wstrb_lane;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign valid = cpu_re | cpu_we;

   always_comb begin
      case (cpu_dm_ctrl)
         3'b000:         aligned = (cpu_addr[1:0] == 2'b00);
         3'b001, 3'b010: aligned = ~cpu_addr[0];
         3'b011, 3'b100: aligned = 1'b1;
         default:        aligned = 1'b0;
      endcase
   end

   assign accept      = (state == IDLE) && valid && aligned;
   assign ack_hit     = (state == REQ) && mem_ack;
   // an ack on the final cycle still wins over the abort
   assign timeout_hit = (state == REQ) && !mem_ack && (tmo_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = REQ;
         REQ:     if (ack_hit || timeout_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // gated by reset so stall drops the moment reset is asserted
   always_comb begin
      cpu_stall    = 1'b0;
      misalign_err = 1'b0;
      if (reset) begin
         case (state)
            IDLE: begin
               cpu_stall    = valid && aligned;
               misalign_err = valid && !aligned;
            end
            REQ:     cpu_stall = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      wdata_lane = cpu_wdata;
      wstrb_lane = 4'b1111;
      case (cpu_dm_ctrl)
         3'b001, 3'b010: begin
            wdata_lane = {2{cpu_wdata[15:0]}};
            wstrb_lane = cpu_addr[1] ? 4'b1100 : 4'b0011;
         end
         3'b011, 3'b100: begin
            wdata_lane = {4{cpu_wdata[7:0]}};
            wstrb_lane = 4'b0001 << cpu_addr[1:0];
         end
         default: ;
      endcase
      if (!cpu_we) wstrb_lane = 4'b0000;
   end

   always_comb begin
      byte_lane = mem_rdata[{lat_off, 3'b000} +: 8];
      half_lane = mem_rdata[{lat_off[1], 4'b0000} +: 16];
      case (lat_dm)
         3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
         3'b010:  load_ext = {16'h0000, half_lane};
         3'b011:  load_ext = {{24{byte_lane[7]}}, byte_lane};
         3'b100:  load_ext = {24'h000000, byte_lane};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         lat_off   <= '0;
         lat_dm    <= '0;
         tmo_cnt   <= '0;
         cpu_rdata <= '0;
         bus_err   <= 1'b0;
      end else begin
         bus_err <= timeout_hit;
         if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= wdata_lane;
            mem_wstrb <= wstrb_lane;
            lat_off   <= cpu_addr[1:0];
            lat_dm    <= cpu_dm_ctrl;
            tmo_cnt   <= '0;
         end else if (ack_hit || timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (timeout_hit)  cpu_rdata <= '0;
            else if (!mem_we) cpu_rdata <= load_ext;
         end else if (state == REQ) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_dmem_bus_if.sv
// tb/tb_dmem_bus_if.sv - scoreboard bench for dmem_bus_if
module tb_dmem_bus_if;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_re = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [2:0]  cpu_dm_ctrl = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_stall, misalign_err, bus_err;
   logic        mem_req, mem_we, mem_ack = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [3:0]  mem_wstrb;

   dmem_bus_if #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_dm_ctrl(cpu_dm_ctrl), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .misalign_err(misalign_err), .bus_err(bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mis;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] bmem [0:255];
   logic [31:0] rmem [0:255];
   logic [31:0] last_rdata = '0;
   int          n_cmp = 0, n_err = 0, req_rises = 0;

   always @(posedge mem_req) req_rises++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic re, input logic we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [2:0] dm, input int lat);
      exp_t        e;
      logic [31:0] w;
      e.we = we; e.addr = {a[31:2], 2'b00}; e.wdata = wd; e.strb = 4'b0000;
      case (dm)
         3'd0:       e.mis = (a[1:0] != 2'b00);
         3'd1, 3'd2: e.mis = a[0];
         3'd3, 3'd4: e.mis = 1'b0;
         default:    e.mis = 1'b1;
      endcase
      if (we) begin
         if (dm == 3'd3 || dm == 3'd4) begin
            e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            case (a[1:0]) 2'd0: e.strb = 4'b0001; 2'd1: e.strb = 4'b0010;
                          2'd2: e.strb = 4'b0100; default: e.strb = 4'b1000; endcase
         end else if (dm == 3'd1 || dm == 3'd2) begin
            e.wdata = {wd[15:0], wd[15:0]};
            e.strb  = a[1] ? 4'b1100 : 4'b0011;
         end else e.strb = 4'b1111;
      end
      e.rdata = last_rdata;
      if (!e.mis) begin
         if (lat < 0) e.rdata = 32'h0;
         else if (we) begin
            for (int i = 0; i < 4; i++)
               if (e.strb[i]) rmem[a[9:2]][8*i +: 8] = e.wdata[8*i +: 8];
         end else begin
            w = rmem[a[9:2]];
            case (dm)
               3'd1: begin w = w >> (16 * a[1]); e.rdata = {{16{w[15]}}, w[15:0]}; end
               3'd2: begin w = w >> (16 * a[1]); e.rdata = {16'h0, w[15:0]}; end
               3'd3: begin w = w >> (8 * a[1:0]); e.rdata = {{24{w[7]}}, w[7:0]}; end
               3'd4: begin w = w >> (8 * a[1:0]); e.rdata = {24'h0, w[7:0]}; end
               default: e.rdata = w;
            endcase
         end
         last_rdata = e.rdata;
      end
      return e;
   endfunction

   task automatic idle_inputs();
      cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_dm_ctrl = '0;
   endtask

   // lat = REQ cycle index carrying the ack; negative means no ack (timeout)
   task automatic access(input logic re, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] dm, input int lat);
      exp_t e;
      int   nreq, stalls;
      sb.push_back(model(re, we, a, wd, dm, lat));
      @(posedge clk); #1;
      cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_dm_ctrl = dm;
      #1;
      if (sb.size() == 0) begin check("sb_empty", 1, 0); return; end
      e = sb.pop_front();
      if (e.mis) begin
         check("misalign_err", misalign_err, 1);
         check("mis_stall", cpu_stall, 0);
         @(posedge clk); #1;
         check("mis_no_req", mem_req, 0);
         idle_inputs();
         return;
      end
      check("accept_no_mis", misalign_err, 0);
      check("accept_stall", cpu_stall, 1);
      stalls = int'(cpu_stall);
      nreq = (lat < 0) ? TMO : lat + 1;
      for (int k = 0; k < nreq; k++) begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         check("mem_req", mem_req, 1);
         check("mem_we", mem_we, e.we);
         check("mem_addr", mem_addr, e.addr);
         check("mem_wstrb", mem_wstrb, e.strb);
         if (e.we) check("mem_wdata", mem_wdata, e.wdata);
         stalls += int'(cpu_stall);
         if (k == lat) begin
            mem_ack = 1'b1;
            if (mem_we) begin
               for (int i = 0; i < 4; i++)
                  if (mem_wstrb[i]) bmem[mem_addr[9:2]][8*i +: 8] = mem_wdata[8*i +: 8];
            end else mem_rdata = bmem[mem_addr[9:2]];
         end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      check("done_req", mem_req, 0);
      check("done_stall", cpu_stall, 0);
      check("done_mis", misalign_err, 0);
      check("done_bus_err", bus_err, (lat < 0) ? 1 : 0);
      check("cpu_rdata", cpu_rdata, e.rdata);
      check("stall_cycles", stalls, nreq + 1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin bmem[i] = '0; rmem[i] = '0; end
      bmem[8'h80] = 32'h8001_1234; rmem[8'h80] = 32'h8001_1234;
      #2;
      check("rst_req", mem_req, 0);
      check("rst_stall", cpu_stall, 0);
      check("rst_rdata", cpu_rdata, 0);
      check("rst_wstrb", mem_wstrb, 0);
      check("rst_bus_err", bus_err, 0);
      @(posedge clk); #1; reset = 1'b1;

      access(1'b0, 1'b1, 32'h103, 32'h0000_00A5, 3'd3, 0);
      access(1'b1, 1'b0, 32'h202, 32'h0, 3'd1, 2);
      check("half_signed", cpu_rdata, 32'hFFFF_8001);
      access(1'b1, 1'b0, 32'h202, 32'h0, 3'd2, 1);
      check("half_unsigned", cpu_rdata, 32'h0000_8001);
      access(1'b1, 1'b0, 32'h006, 32'h0, 3'd0, 0);
      idle_inputs();

      access(1'b1, 1'b0, 32'h020, 32'h0, 3'd0, -1);
      @(posedge clk); #1;
      idle_inputs(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("late_ack_req", mem_req, 0);
      check("late_ack_stall", cpu_stall, 0);
      check("late_ack_rdata", cpu_rdata, 0);
      check("late_ack_bus_err", bus_err, 0);

      req_rises = 0;
      access(1'b0, 1'b1, 32'h010, 32'hCAFE_F00D, 3'd0, 0);
      access(1'b1, 1'b0, 32'h010, 32'h0, 3'd0, 1);
      check("b2b_load", cpu_rdata, 32'hCAFE_F00D);
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
      check("b2b_req_count", req_rises, 2);

      for (int n = 0; n < 16; n++) begin
         logic [1:0] rw;
         rw = 2'($urandom_range(1, 3));
         access(rw[0], rw[1], 32'h300 + 32'($urandom_range(0, 63)), $urandom,
                3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      end
      @(posedge clk); #1;
      idle_inputs();

      @(posedge clk); #1;
      cpu_re = 1'b1; cpu_addr = 32'h40; cpu_dm_ctrl = 3'd0;
      @(posedge clk); #1;
      check("pre_rst_req", mem_req, 1);
      #2; reset = 1'b0; mem_ack = 1'b1; #1;
      check("async_rst_req", mem_req, 0);
      check("async_rst_stall", cpu_stall, 0);
      @(posedge clk); #1;
      reset = 1'b1; idle_inputs();
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("post_rst_req", mem_req, 0);
      check("post_rst_rdata", cpu_rdata, 0);
      last_rdata = '0;
      access(1'b1, 1'b0, 32'h010, 32'h0, 3'd0, 0);
      @(posedge clk); #1;
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
- Memory-stage data-access unit between the pipelined core's MEM-stage outputs (address, store data, dm_ctrl, write enable) and a req/ack data bus.
- Converts byte, halfword and word accesses into aligned word transactions with byte strobes.
- Sign- or zero-extends load data before it returns to the core for the MEM/WB register.
- Stalls the pipeline while a transaction is outstanding and reports misalignment and timeout errors.

Parameters:
- TIMEOUT, 16: maximum cycles in REQ without mem_ack before the access is aborted (range 1..255).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; reset=0 clears all state immediately
- cpu_re  in  1  MEM-stage load request
- cpu_we  in  1  MEM-stage store request (MemWrite)
- cpu_addr  in  ADDR_W  byte address (ALU result)
- cpu_wdata  in  32  store data, right-aligned
- cpu_dm_ctrl  in  3  000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned
- cpu_rdata  out  32  extended load data, valid in DONE
- cpu_stall  out  1  freeze PC and IF/ID/ID_EX/EX_MEM; hold MEM_WB
- misalign_err  out  1  one-cycle pulse on a misaligned request
- bus_err  out  1  one-cycle pulse on timeout
- mem_req  out  1  bus request, registered
- mem_we  out  1  bus write, registered
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}), registered
- mem_wdata  out  32  lane-replicated store data, registered
- mem_wstrb  out  4  byte strobes; 0000 for loads
- mem_ack  in  1  bus completion; sampled on the rising edge
- mem_rdata  in  32  read data; valid when mem_ack=1

Behaviour:
- States: IDLE, REQ, DONE. Reset puts the FSM in IDLE, all outputs 0, and cpu_rdata=0.
- Valid request: cpu_re|cpu_we. If both are high, the store takes priority and the load is ignored.
- Alignment rules: word needs addr[1:0]=00; half needs addr[0]=0; byte is always aligned. An illegal dm_ctrl code (101..111) is treated as misaligned.
- IDLE + valid + aligned:
  - cpu_stall=1 combinationally in the same cycle.
  - Latch address, data, dm_ctrl and we; go to REQ next cycle with mem_req=1.
- IDLE + valid + misaligned:
  - misalign_err=1 for that cycle; no bus transaction; cpu_stall=0; stay in IDLE.
- REQ:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are held stable; cpu_stall=1.
  - An 8-bit timeout counter starts at 0 on entry and increments each cycle without mem_ack.
- REQ, mem_ack=1 at the edge:
  - Drop mem_req next cycle and go to DONE.
  - Load: capture the extended lane into cpu_rdata.
  - Store: cpu_rdata is unchanged.
- REQ, counter reaches TIMEOUT-1 with no ack:
  - Go to DONE, drop mem_req, set cpu_rdata=0, pulse bus_err=1 during DONE.
  - An ack arriving after the abort is ignored.
- DONE:
  - cpu_stall=0 so the pipeline advances at the end of this cycle.
  - Request inputs are ignored in DONE.
  - Next state is IDLE.
- Latency: an aligned access with ack in the first REQ cycle stalls for 2 cycles; the result is visible in the 3rd cycle (DONE).
- Store lane mapping:
  - byte: wdata={4{b}}, wstrb=0001<<addr[1:0]
  - half: wdata={2{h}}, wstrb=0011 if addr[1]=0, else 1100
  - word: wstrb=1111
- Load extraction:
  - byte lane = rdata[8*addr[1:0]+:8]; half lane = rdata[16*addr[1]+:16].
  - Signed codes sign-extend bit 7 or bit 15; unsigned codes zero-extend.
- Reset asserted mid-REQ: mem_req and cpu_stall go to 0 asynchronously; the FSM returns to IDLE and any late ack is ignored.

Test Plan:
- Byte store: we=1, addr=0x103, wdata=0x000000A5, dm=011 → REQ with mem_addr=0x100, wdata=0xA5A5A5A5, wstrb=1000; ack next cycle → stall high exactly 2 cycles.
- Signed half load: re=1, addr=0x202, dm=001, ack with rdata=0x8001_1234 after 3 REQ cycles → cpu_rdata=0xFFFF8001 in DONE; with dm=010 → 0x00008001.
- Misaligned: word load at addr=0x006 → misalign_err pulse, mem_req never asserted, cpu_stall=0.
- Timeout: TIMEOUT=4, no ack → mem_req high 4 cycles, then DONE with bus_err=1, cpu_rdata=0; a late ack in IDLE causes no change.
- Back-to-back: store to 0x10 then load from 0x10 on consecutive MEM instructions → two separate transactions, no duplicate request from DONE, load returns the stored value from the bus model.
- Reset mid-REQ: reset=0 while mem_req=1 → mem_req and cpu_stall drop without waiting for a clock edge; after release the next request starts cleanly from IDLE.
